// File: rtl/fft_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_pipe_ctrl_if
// Description : Handshake/qualifier bundle between the FFT sample source and
//               the pipeline sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_pipe_ctrl_if #(
  parameter int AW = 4
);
  logic          i_valid;
  logic          i_sync;
  logic          o_coeff_s1_en;
  logic [AW-1:0] o_coeff_s1_addr;
  logic          o_coeff_s2_en;
  logic [AW-1:0] o_coeff_s2_addr;
  logic          o_bfii_ctrl;
  logic          o_out_valid;
  logic [AW-1:0] o_out_idx;
  logic          o_frame_start;
  logic          o_busy;

  // Sample source side: drives advance/realign, observes the schedule
  modport master (
    output i_valid, i_sync,
    input  o_coeff_s1_en, o_coeff_s1_addr, o_coeff_s2_en, o_coeff_s2_addr,
           o_bfii_ctrl, o_out_valid, o_out_idx, o_frame_start, o_busy
  );

  // Controller side
  modport slave (
    input  i_valid, i_sync,
    output o_coeff_s1_en, o_coeff_s1_addr, o_coeff_s2_en, o_coeff_s2_addr,
           o_bfii_ctrl, o_out_valid, o_out_idx, o_frame_start, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/fft_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_pipe_ctrl
// Description : Sequencing controller for the radix-2^2 streaming FFT. Counts
//               advance cycles (valid and not realigning) to schedule the
//               stage-1/stage-2 coefficient enables and addresses, the BFII
//               select and the output valid/index qualifiers.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_pipe_ctrl #(
  parameter int N        = 32,
  parameter int DELAY_S1 = 1,
  parameter int DELAY_S2 = 16,
  parameter int AW       = $clog2(N/2)
) (
  input  wire             clk,
  input  wire             rst,
  fft_pipe_ctrl_if.slave  bus
);

  localparam int HALF = N / 2;
  localparam int FCW  = $clog2(DELAY_S1 + DELAY_S2 + 1);
  localparam int BCW  = (DELAY_S2 > 1) ? $clog2(DELAY_S2) : 1;

  localparam logic [AW-1:0]  ADDR_LAST = AW'(HALF - 1);
  localparam logic [FCW-1:0] FC_S1_END = FCW'(DELAY_S1 - 1);
  localparam logic [FCW-1:0] FC_S2_END = FCW'(DELAY_S1 + DELAY_S2 - 1);
  localparam logic [BCW-1:0] BC_LAST   = BCW'(DELAY_S2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic           s1_en_q, s1_en_d;
  logic [AW-1:0]  s1_addr_q, s1_addr_d;
  logic           s2_en_q, s2_en_d;
  logic [AW-1:0]  s2_addr_q, s2_addr_d;
  logic           ctrl_q, ctrl_d;
  logic           valid_q, valid_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           fs_q, fs_d;

  // Next-state and schedule: everything holds unless an advance occurs;
  // realign clears the whole schedule and swallows any coincident sample.
  always_comb begin
    state_d   = state_q;
    fc_d      = fc_q;
    bc_d      = bc_q;
    s1_en_d   = s1_en_q;
    s1_addr_d = s1_addr_q;
    s2_en_d   = s2_en_q;
    s2_addr_d = s2_addr_q;
    ctrl_d    = ctrl_q;
    valid_d   = 1'b0;
    idx_d     = idx_q;
    fs_d      = 1'b0;

    if (bus.i_sync) begin
      state_d   = IDLE;
      fc_d      = '0;
      bc_d      = '0;
      s1_en_d   = 1'b0;
      s1_addr_d = '0;
      s2_en_d   = 1'b0;
      s2_addr_d = '0;
      ctrl_d    = 1'b0;
      idx_d     = '0;
    end else if (bus.i_valid) begin
      // Output qualifiers track the stage-2 address that goes with this sample
      valid_d = s2_en_q;
      idx_d   = s2_addr_q;
      fs_d    = s2_en_q && (s2_addr_q == '0);

      if (s1_en_q) begin
        s1_addr_d = (s1_addr_q == ADDR_LAST) ? '0 : s1_addr_q + AW'(1);
      end
      if (s2_en_q) begin
        s2_addr_d = (s2_addr_q == ADDR_LAST) ? '0 : s2_addr_q + AW'(1);
      end

      unique case (state_q)
        IDLE: begin
          fc_d = FCW'(1);
          if (DELAY_S1 == 1) begin
            state_d = FILL2;
            s1_en_d = 1'b1;
          end else begin
            state_d = FILL1;
          end
        end
        FILL1: begin
          fc_d = fc_q + FCW'(1);
          if (fc_q == FC_S1_END) begin
            state_d = FILL2;
            s1_en_d = 1'b1;
          end
        end
        FILL2: begin
          fc_d = fc_q + FCW'(1);
          if (fc_q == FC_S2_END) begin
            state_d = RUN;
            s2_en_d = 1'b1;
            bc_d    = '0;
            ctrl_d  = 1'b0;
          end
        end
        RUN: begin
          // BFII select flips once every DELAY_S2 advances
          if (bc_q == BC_LAST) begin
            bc_d   = '0;
            ctrl_d = ~ctrl_q;
          end else begin
            bc_d = bc_q + BCW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; active-low synchronous reset clears all
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      fc_q      <= '0;
      bc_q      <= '0;
      s1_en_q   <= 1'b0;
      s1_addr_q <= '0;
      s2_en_q   <= 1'b0;
      s2_addr_q <= '0;
      ctrl_q    <= 1'b0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      fc_q      <= fc_d;
      bc_q      <= bc_d;
      s1_en_q   <= s1_en_d;
      s1_addr_q <= s1_addr_d;
      s2_en_q   <= s2_en_d;
      s2_addr_q <= s2_addr_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.o_coeff_s1_en   = s1_en_q;
  assign bus.o_coeff_s1_addr = s1_addr_q;
  assign bus.o_coeff_s2_en   = s2_en_q;
  assign bus.o_coeff_s2_addr = s2_addr_q;
  assign bus.o_bfii_ctrl     = ctrl_q;
  assign bus.o_out_valid     = valid_q;
  assign bus.o_out_idx       = idx_q;
  assign bus.o_frame_start   = fs_q;
  assign bus.o_busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fft_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_pipe_ctrl
// Description : Self-checking bench for fft_pipe_ctrl. Expected outputs are
//               derived from the count of advances since the last flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_pipe_ctrl;

  localparam int N  = 32;
  localparam int S1 = 1;
  localparam int S2 = 16;
  localparam int H  = N / 2;
  localparam int AW = 4;

  logic clk;
  logic rst;
  fft_pipe_ctrl_if #(.AW(AW)) bus ();

  fft_pipe_ctrl #(.N(N), .DELAY_S1(S1), .DELAY_S2(S2), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: advances since last flush, and output stage
  int          m_k;
  logic        m_valid;
  logic [3:0]  m_idx;
  logic        m_fs;
  logic [17:0] sb[$];
  logic [17:0] exp_v;

  function automatic logic [17:0] obs_vec();
    return {bus.o_coeff_s1_en, bus.o_coeff_s1_addr, bus.o_coeff_s2_en,
            bus.o_coeff_s2_addr, bus.o_bfii_ctrl, bus.o_out_valid,
            bus.o_out_idx, bus.o_frame_start, bus.o_busy};
  endfunction

  function automatic logic [17:0] model_vec();
    logic       e1, e2, ct, busy;
    logic [3:0] a1, a2;
    e1 = (m_k >= S1);
    e2 = (m_k >= S1 + S2);
    a1 = e1 ? 4'((m_k - S1) % H) : 4'd0;
    a2 = e2 ? 4'((m_k - S1 - S2) % H) : 4'd0;
    ct = e2 ? (((m_k - S1 - S2) / S2) % 2 == 1) : 1'b0;
    busy = (m_k > 0);
    return {e1, a1, e2, a2, ct, m_valid, m_idx, m_fs, busy};
  endfunction

  // Drive one clock of stimulus, push the expected post-edge outputs,
  // and return #1 after the active edge ready for sampling.
  task automatic step(input logic v, input logic s, input logic r);
    @(negedge clk);
    bus.i_valid = v;
    bus.i_sync  = s;
    rst         = r;
    if (!r || s) begin
      m_k = 0; m_valid = 1'b0; m_idx = 4'd0; m_fs = 1'b0;
    end else if (v) begin
      m_valid = (m_k >= S1 + S2);
      m_idx   = m_valid ? 4'((m_k - S1 - S2) % H) : 4'd0;
      m_fs    = m_valid && (m_idx == 4'd0);
      m_k     = m_k + 1;
    end else begin
      m_valid = 1'b0;
      m_fs    = 1'b0;
    end
    sb.push_back(model_vec());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v || obs_vec() !== 18'd0) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got=%h exp=%h", c, obs_vec(), exp_v);
      end
    end
    step(1'b1, 1'b0, 1'b1);
    exp_v = sb.pop_front();
    n_checks++;
    if (bus.o_busy !== 1'b1 || obs_vec() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release busy=%b got=%h exp=%h", bus.o_busy, obs_vec(), exp_v);
    end
  endtask

  task automatic test_continuous();
    step(1'b0, 1'b1, 1'b1);
    exp_v = sb.pop_front();
    for (int c = 0; c < 60; c++) begin
      step(1'b1, 1'b0, 1'b1);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL continuous cyc=%0d got=%h exp=%h", c + 1, obs_vec(), exp_v);
      end
      if (c + 1 == 1 || c + 1 == 17) begin
        n_checks++;
        if (bus.o_coeff_s1_en !== 1'b1 || bus.o_coeff_s2_en !== (c + 1 == 17)) begin
          n_fail++;
          $display("FAIL cont_enables cyc=%0d s1=%b s2=%b", c + 1, bus.o_coeff_s1_en, bus.o_coeff_s2_en);
        end
      end
      if (c + 1 == 16 || c + 1 == 17) begin
        n_checks++;
        if (bus.o_coeff_s1_addr !== ((c + 1 == 16) ? 4'd15 : 4'd0)) begin
          n_fail++;
          $display("FAIL cont_s1_wrap cyc=%0d got=%0d", c + 1, bus.o_coeff_s1_addr);
        end
      end
      if (c + 1 == 18 || c + 1 == 34 || c + 1 == 50) begin
        n_checks++;
        if (bus.o_frame_start !== 1'b1 || bus.o_out_valid !== 1'b1 || bus.o_out_idx !== 4'd0) begin
          n_fail++;
          $display("FAIL cont_frame_start cyc=%0d fs=%b v=%b idx=%0d exp 1 1 0",
                   c + 1, bus.o_frame_start, bus.o_out_valid, bus.o_out_idx);
        end
      end
      if (c + 1 == 32 || c + 1 == 33 || c + 1 == 48 || c + 1 == 49) begin
        n_checks++;
        if (bus.o_bfii_ctrl !== (c + 1 == 33 || c + 1 == 48)) begin
          n_fail++;
          $display("FAIL cont_bfii cyc=%0d got=%b", c + 1, bus.o_bfii_ctrl);
        end
      end
    end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, 1'b1);
    exp_v = sb.pop_front();
    for (int c = 0; c < 22; c++) begin
      step((c < 10 || c > 12), 1'b0, 1'b1);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL stall cyc=%0d got=%h exp=%h", c + 1, obs_vec(), exp_v);
      end
      if (c + 1 >= 10 && c + 1 <= 12) begin
        n_checks++;
        if (bus.o_coeff_s1_addr !== 4'd9) begin
          n_fail++;
          $display("FAIL stall_s1_hold cyc=%0d got=%0d exp=9", c + 1, bus.o_coeff_s1_addr);
        end
      end
      if (c + 1 == 17 || c + 1 == 19 || c + 1 == 20) begin
        n_checks++;
        if (bus.o_coeff_s2_en !== (c + 1 == 20)) begin
          n_fail++;
          $display("FAIL stall_s2_en cyc=%0d got=%b", c + 1, bus.o_coeff_s2_en);
        end
      end
    end
  endtask

  task automatic test_stall_run();
    step(1'b0, 1'b1, 1'b1);
    exp_v = sb.pop_front();
    for (int c = 0; c < 32; c++) begin
      step(!(c == 25 || c == 26), 1'b0, 1'b1);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL stall_run cyc=%0d got=%h exp=%h", c + 1, obs_vec(), exp_v);
      end
      if (c + 1 == 26 || c + 1 == 27) begin
        n_checks++;
        if (bus.o_out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_run_valid cyc=%0d got=%b exp=0", c + 1, bus.o_out_valid);
        end
      end
      if (c + 1 == 28) begin
        n_checks++;
        if (bus.o_out_valid !== 1'b1 || bus.o_out_idx !== 4'd8) begin
          n_fail++;
          $display("FAIL stall_run_resume v=%b idx=%0d exp 1 8", bus.o_out_valid, bus.o_out_idx);
        end
      end
    end
  endtask

  task automatic test_sync_midrun();
    step(1'b0, 1'b1, 1'b1);
    exp_v = sb.pop_front();
    for (int c = 0; c < 62; c++) begin
      step(1'b1, (c == 40), 1'b1);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL sync cyc=%0d got=%h exp=%h", c + 1, obs_vec(), exp_v);
      end
      if (c + 1 == 41) begin
        n_checks++;
        if (obs_vec() !== 18'd0) begin
          n_fail++;
          $display("FAIL sync_clear got=%h exp=0", obs_vec());
        end
      end
      if (c + 1 == 42 || c + 1 == 58) begin
        n_checks++;
        if (bus.o_coeff_s1_en !== 1'b1 || bus.o_coeff_s2_en !== (c + 1 == 58)) begin
          n_fail++;
          $display("FAIL sync_restart cyc=%0d s1=%b s2=%b", c + 1, bus.o_coeff_s1_en, bus.o_coeff_s2_en);
        end
      end
      if (c + 1 == 59) begin
        n_checks++;
        if (bus.o_out_valid !== 1'b1 || bus.o_out_idx !== 4'd0 || bus.o_frame_start !== 1'b1) begin
          n_fail++;
          $display("FAIL sync_first_out v=%b idx=%0d fs=%b exp 1 0 1",
                   bus.o_out_valid, bus.o_out_idx, bus.o_frame_start);
        end
      end
    end
  endtask

  task automatic test_reset_midfill();
    step(1'b0, 1'b1, 1'b1);
    exp_v = sb.pop_front();
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 1'b0, (c != 8));
      exp_v = sb.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL rst_midfill cyc=%0d got=%h exp=%h", c + 1, obs_vec(), exp_v);
      end
      if (c + 1 == 9) begin
        n_checks++;
        if (obs_vec() !== 18'd0) begin
          n_fail++;
          $display("FAIL rst_midfill_clear got=%h exp=0", obs_vec());
        end
      end
      if (c + 1 == 25 || c + 1 == 26) begin
        n_checks++;
        if (bus.o_coeff_s2_en !== (c + 1 == 26)) begin
          n_fail++;
          $display("FAIL rst_midfill_s2 cyc=%0d got=%b", c + 1, bus.o_coeff_s2_en);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic v, s, r;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 60) == 0);
      r = ($urandom_range(0, 120) != 0);
      step(v, s, r);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL random c=%0d v=%b s=%b r=%b got=%h exp=%h", c, v, s, r, obs_vec(), exp_v);
      end
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sync  = 1'b0;
    m_k = 0; m_valid = 1'b0; m_idx = 4'd0; m_fs = 1'b0;
    test_reset();
    test_continuous();
    test_stall();
    test_stall_run();
    test_sync_midrun();
    test_reset_midfill();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
